// File: rtl/clk_gen_ctrl_if.sv
// Request/status bundle between the rate controller and its user/divider side.
// Optional tick_cnt member exists only when CLK_GEN_CTRL_TICK_CNT_EN is defined.
interface clk_gen_ctrl_if #(
  parameter int SEL_W = 5
);
  logic             faster;
  logic             slower;
  logic             run;
  logic             clk_gen_in;
  logic             clk_gen_rst;
  logic [SEL_W-1:0] clk_gen_s;
  logic             tick;
  logic             busy;
  logic             limit;
`ifdef CLK_GEN_CTRL_TICK_CNT_EN
  logic [15:0]      tick_cnt;

  modport master (
    output faster, slower, run, clk_gen_in,
    input  clk_gen_rst, clk_gen_s, tick, busy, limit, tick_cnt
  );
  modport slave (
    input  faster, slower, run, clk_gen_in,
    output clk_gen_rst, clk_gen_s, tick, busy, limit, tick_cnt
  );
`else
  modport master (
    output faster, slower, run, clk_gen_in,
    input  clk_gen_rst, clk_gen_s, tick, busy, limit
  );
  modport slave (
    input  faster, slower, run, clk_gen_in,
    output clk_gen_rst, clk_gen_s, tick, busy, limit
  );
`endif
endinterface

// File: rtl/clk_gen_ctrl.sv
// Rate controller for clk_gen: steps the divider select, restarts the divider on every
// change/resume, and turns its feedback into one-cycle ticks. Option: CLK_GEN_CTRL_TICK_CNT_EN.
module clk_gen_ctrl #(
  parameter  int SIZE    = 26,
  parameter  int DEF_SEL = SIZE - 1,
  parameter  int MIN_SEL = 0,
  localparam int SEL_W   = $clog2(SIZE)
) (
  input  logic          fsys,
  input  logic          clk_gen_ctrl_rst_n,
  clk_gen_ctrl_if.slave bus
);
  localparam logic [SEL_W-1:0] S_MIN = SEL_W'(MIN_SEL);
  localparam logic [SEL_W-1:0] S_MAX = SEL_W'(SIZE - 1);
  localparam logic [SEL_W-1:0] S_DEF = SEL_W'(DEF_SEL);

  typedef enum logic [1:0] {APPLY = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_rcnt, w_rcnt_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_prev, r_tick, r_rst, r_busy, r_limit;
  logic             w_req_f, w_req_s, w_can_f, w_can_s;
  logic             w_prev_nxt, w_tick_nxt;

  // Simultaneous faster+slower cancel each other out.
  assign w_req_f = bus.faster & ~bus.slower;
  assign w_req_s = bus.slower & ~bus.faster;
  assign w_can_f = w_req_f && (r_sel > S_MIN);
  assign w_can_s = w_req_s && (r_sel < S_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rcnt_nxt  = 2'd0;
    case (r_state)
      APPLY: begin
        w_rcnt_nxt = r_rcnt + 2'd1;
        if (r_rcnt == 2'd1) begin
          w_state_nxt = bus.run ? RUN : PAUSE;
          w_rcnt_nxt  = 2'd0;
        end
      end
      RUN: begin
        if (!bus.run) begin
          w_state_nxt = PAUSE;
        end else if (w_can_f) begin
          w_sel_nxt   = r_sel - 1'b1;
          w_state_nxt = APPLY;
        end else if (w_can_s) begin
          w_sel_nxt   = r_sel + 1'b1;
          w_state_nxt = APPLY;
        end
      end
      PAUSE: begin
        if (w_can_f)      w_sel_nxt = r_sel - 1'b1;
        else if (w_can_s) w_sel_nxt = r_sel + 1'b1;
        if (bus.run)      w_state_nxt = APPLY;
      end
      default: w_state_nxt = APPLY;
    endcase
    // The divider output is held low in APPLY, so the edge detector restarts from 0.
    w_prev_nxt = (r_state == APPLY) ? 1'b0 : bus.clk_gen_in;
    w_tick_nxt = bus.clk_gen_in & ~r_prev & (r_state == RUN);
  end

  always_ff @(posedge fsys) begin
    if (!clk_gen_ctrl_rst_n) begin
      r_state <= APPLY;
      r_rcnt  <= 2'd0;
      r_sel   <= S_DEF;
      r_rst   <= 1'b1;
      r_tick  <= 1'b0;
      r_busy  <= 1'b1;
      r_prev  <= 1'b0;
      r_limit <= (S_DEF == S_MIN) || (S_DEF == S_MAX);
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_sel   <= w_sel_nxt;
      r_rst   <= (w_state_nxt != RUN);
      r_tick  <= w_tick_nxt;
      r_busy  <= (w_state_nxt == APPLY);
      r_prev  <= w_prev_nxt;
      r_limit <= (w_sel_nxt == S_MIN) || (w_sel_nxt == S_MAX);
    end
  end

`ifdef CLK_GEN_CTRL_TICK_CNT_EN
  logic [15:0] r_tick_cnt;

  always_ff @(posedge fsys) begin
    if (!clk_gen_ctrl_rst_n || (w_sel_nxt != r_sel)) r_tick_cnt <= 16'd0;
    else if (w_tick_nxt)                              r_tick_cnt <= r_tick_cnt + 16'd1;
  end

  assign bus.tick_cnt = r_tick_cnt;
`endif

  assign bus.clk_gen_rst = r_rst;
  assign bus.clk_gen_s   = r_sel;
  assign bus.tick        = r_tick;
  assign bus.busy        = r_busy;
  assign bus.limit       = r_limit;
endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Randomized bench for clk_gen_ctrl with a cycle-level reference model and
// directed literal checks; clk_gen is emulated as a square wave held low in reset.
module tb_clk_gen_ctrl;
  localparam int SIZE    = 4;
  localparam int DEF_SEL = 3;
  localparam int MIN_SEL = 0;
  localparam int SEL_W   = 2;

  logic fsys  = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   half   = 4;
  int   ph     = 0;

  clk_gen_ctrl_if #(.SEL_W(SEL_W)) ifc ();

  clk_gen_ctrl #(.SIZE(SIZE), .DEF_SEL(DEF_SEL), .MIN_SEL(MIN_SEL)) dut (
    .fsys               (fsys),
    .clk_gen_ctrl_rst_n (rst_n),
    .bus                (ifc)
  );

  always #5 fsys = ~fsys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Divider emulation: output restarts low whenever the controller holds it in reset.
  initial begin
    ifc.clk_gen_in = 1'b0;
    forever begin
      @(posedge fsys);
      #1;
      if (ifc.clk_gen_rst !== 1'b0) begin
        ph = 0;
        ifc.clk_gen_in = 1'b0;
      end else begin
        ph = (ph + 1) % (2 * half);
        ifc.clk_gen_in = (ph >= half);
      end
    end
  end

  // Reference model: mode plus remaining restart cycles.
  typedef enum {M_APPLY, M_RUN, M_PAUSE} mmode_t;
  mmode_t mode    = M_APPLY;
  int     left    = 2;
  int     m_s     = DEF_SEL;
  int     m_cnt   = 0;
  bit     m_prev  = 0;
  bit     m_tick  = 0;
  bit     m_valid = 0;

  initial begin
    forever begin
      bit f, sl, r, ci, nt, one;
      int want, old_s;
      @(posedge fsys);
      f = ifc.faster; sl = ifc.slower; r = ifc.run; ci = ifc.clk_gen_in;
      if (!rst_n) begin
        mode = M_APPLY; left = 2; m_s = DEF_SEL; m_prev = 0; m_tick = 0; m_cnt = 0;
        m_valid = 1;
      end else begin
        nt     = ci && !m_prev && (mode == M_RUN);
        m_prev = (mode == M_APPLY) ? 1'b0 : ci;
        old_s  = m_s;
        one    = f ^ sl;
        want   = f ? m_s - 1 : m_s + 1;
        if (!(want >= MIN_SEL && want <= SIZE - 1)) one = 0;
        case (mode)
          M_APPLY: begin
            left--;
            if (left == 0) mode = r ? M_RUN : M_PAUSE;
          end
          M_RUN: begin
            if (!r) mode = M_PAUSE;
            else if (one) begin m_s = want; mode = M_APPLY; left = 2; end
          end
          default: begin
            if (one) m_s = want;
            if (r) begin mode = M_APPLY; left = 2; end
          end
        endcase
        m_tick = nt;
        if (m_s != old_s) m_cnt = 0;
        else if (nt)      m_cnt = (m_cnt + 1) % 65536;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge fsys);
      if (m_valid) begin
        chk("m_clk_gen_rst", ifc.clk_gen_rst, (mode != M_RUN));
        chk("m_busy",        ifc.busy,        (mode == M_APPLY));
        chk("m_clk_gen_s",   ifc.clk_gen_s,   m_s);
        chk("m_limit",       ifc.limit,       (m_s == MIN_SEL || m_s == SIZE - 1));
        chk("m_tick",        ifc.tick,        m_tick);
`ifdef CLK_GEN_CTRL_TICK_CNT_EN
        chk("m_tick_cnt",    ifc.tick_cnt,    m_cnt);
`endif
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge fsys);
      #2;
    end
  endtask

  task automatic pulse(input bit f, input bit s);
    ifc.faster = f; ifc.slower = s;
    cyc();
    ifc.faster = 1'b0; ifc.slower = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ifc.busy !== 1'b0 && n < 20) begin cyc(); n++; end
    chk("wait_idle", ifc.busy, 0);
  endtask

  task automatic measure_ticks();
    int n = 0;
    while (ifc.tick !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("first_tick_seen", ifc.tick, 1);
    cyc();
    chk("tick_width", ifc.tick, 0);
    n = 1;
    while (ifc.tick !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("tick_period", n, 8);
  endtask

  initial begin
    int nt;
    ifc.faster = 1'b0; ifc.slower = 1'b0; ifc.run = 1'b1;
    cyc(3);
    chk("rst_sel",   ifc.clk_gen_s, 3);
    chk("rst_limit", ifc.limit, 1);
    chk("rst_cgrst", ifc.clk_gen_rst, 1);
    rst_n = 1'b1;
    cyc();
    chk("apply1_cgrst", ifc.clk_gen_rst, 1);
    chk("apply1_busy",  ifc.busy, 1);
    cyc();
    chk("run_cgrst", ifc.clk_gen_rst, 0);
    chk("run_busy",  ifc.busy, 0);

    measure_ticks();

    for (int i = 0; i < 3; i++) begin
      wait_idle();
      pulse(1, 0);
      chk("faster_sel",  ifc.clk_gen_s, 2 - i);
      chk("faster_busy", ifc.busy, 1);
    end
    wait_idle();
    pulse(1, 0);
    chk("faster_at_min_sel",  ifc.clk_gen_s, 0);
    chk("faster_at_min_busy", ifc.busy, 0);
    chk("min_limit",          ifc.limit, 1);

    pulse(1, 1);
    chk("both_sel", ifc.clk_gen_s, 0);
    pulse(0, 1);
    chk("slower_sel", ifc.clk_gen_s, 1);
    pulse(1, 0);
    chk("faster_in_apply_sel", ifc.clk_gen_s, 1);
    wait_idle();

    ifc.run = 1'b0;
    cyc();
    chk("pause_cgrst", ifc.clk_gen_rst, 1);
    nt = 0;
    for (int i = 0; i < 20; i++) begin cyc(); nt += int'(ifc.tick); end
    chk("pause_no_ticks", nt, 0);
    pulse(0, 1);
    chk("pause_slower_sel",  ifc.clk_gen_s, 2);
    chk("pause_slower_busy", ifc.busy, 0);
    ifc.run = 1'b1;
    cyc();
    chk("resume_busy",  ifc.busy, 1);
    cyc();
    chk("resume_cgrst1", ifc.clk_gen_rst, 1);
    cyc();
    chk("resume_cgrst2", ifc.clk_gen_rst, 0);
    measure_ticks();

`ifdef CLK_GEN_CTRL_TICK_CNT_EN
    pulse(0, 1);
    chk("tick_cnt_clear", ifc.tick_cnt, 0);
    wait_idle();
    nt = 0;
    for (int i = 0; i < 80 && nt < 5; i++) begin cyc(); nt += int'(ifc.tick); end
    chk("tick_cnt_five", ifc.tick_cnt, 5);
`endif

    for (int i = 0; i < 3000; i++) begin
      ifc.faster = ($urandom_range(7) == 0);
      ifc.slower = ($urandom_range(7) == 0);
      if ($urandom_range(31) == 0)  ifc.run = ~ifc.run;
      if ($urandom_range(199) == 0) half = $urandom_range(6, 1);
      rst_n = ($urandom_range(499) != 0);
      cyc();
    end
    ifc.faster = 1'b0; ifc.slower = 1'b0; rst_n = 1'b1;
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
